// File: rtl/ahb_two_master_arbiter.sv
// Two-master AHB arbiter: M0 = CPU, M1 = host port, sharing one slave port.
// Define ARB_ROUND_ROBIN_EN to replace fixed M1 > M0 priority with round-robin.
module ahb_two_master_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        m0_hbusreq_i,
    output logic        m0_hgrant_o,
    input  logic [31:0] m0_haddr_i,
    input  logic [1:0]  m0_htrans_i,
    input  logic        m0_hwrite_i,
    input  logic [2:0]  m0_hsize_i,
    input  logic [2:0]  m0_hburst_i,
    input  logic [31:0] m0_hwdata_i,
    input  logic        m1_hbusreq_i,
    output logic        m1_hgrant_o,
    input  logic [31:0] m1_haddr_i,
    input  logic [1:0]  m1_htrans_i,
    input  logic        m1_hwrite_i,
    input  logic [2:0]  m1_hsize_i,
    input  logic [2:0]  m1_hburst_i,
    input  logic [31:0] m1_hwdata_i,
    output logic [31:0] s_haddr_o,
    output logic [1:0]  s_htrans_o,
    output logic        s_hwrite_o,
    output logic [2:0]  s_hsize_o,
    output logic [2:0]  s_hburst_o,
    output logic [31:0] s_hwdata_o,
    input  logic        s_hready_i,
    input  logic [1:0]  s_hresp_i,
    input  logic [31:0] s_hrdata_i,
    output logic        hready_o,
    output logic [1:0]  hresp_o,
    output logic [31:0] hrdata_o,
    output logic        hmaster_o
);

    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

    typedef enum logic [1:0] {PARK_M0 = 2'd0, OWN_M0 = 2'd1, OWN_M1 = 2'd2} state_e;

    state_e           state_q, state_d;
    logic             addr_own_q, addr_own_d;
    logic             data_own_q, data_own_d;
    logic             data_act_q, data_act_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             gnt_idx_q, gnt_idx_d, grant_chg;
    logic             owner_req, other_req, bus_free, hold_hit;
`ifdef ARB_ROUND_ROBIN_EN
    logic             last_owner_q, last_owner_d;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state_q    <= PARK_M0;
            addr_own_q <= 1'b0;
            data_own_q <= 1'b0;
            data_act_q <= 1'b0;
            hold_cnt_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner_q <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            addr_own_q <= addr_own_d;
            data_own_q <= data_own_d;
            data_act_q <= data_act_d;
            hold_cnt_q <= hold_cnt_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner_q <= last_owner_d;
`endif
        end
    end

    // Next grant; arbitration only advances on edges where the slave is ready.
    always_comb begin
        gnt_idx_q = (state_q == OWN_M1);
        owner_req = gnt_idx_q ? m1_hbusreq_i : m0_hbusreq_i;
        other_req = gnt_idx_q ? m0_hbusreq_i : m1_hbusreq_i;
        bus_free  = (state_q == PARK_M0) || !owner_req;
        // A SEQ beat is never cut off mid-burst by the hold limit.
        hold_hit  = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_MAX) && (s_htrans_o != 2'b11);
        state_d   = state_q;
        if (s_hready_i) begin
            if (bus_free) begin
                if (!m0_hbusreq_i && !m1_hbusreq_i)
                    state_d = PARK_M0;
                else if (m0_hbusreq_i && m1_hbusreq_i)
`ifdef ARB_ROUND_ROBIN_EN
                    state_d = last_owner_q ? OWN_M0 : OWN_M1;
`else
                    state_d = OWN_M1;
`endif
                else
                    state_d = m1_hbusreq_i ? OWN_M1 : OWN_M0;
            end else if (hold_hit && other_req) begin
                state_d = gnt_idx_q ? OWN_M0 : OWN_M1;
            end
        end
        gnt_idx_d = (state_d == OWN_M1);
        grant_chg = (gnt_idx_d != gnt_idx_q);
    end

    always_comb begin
        m0_hgrant_o = (state_q != OWN_M1);
        m1_hgrant_o = (state_q == OWN_M1);
    end

    // Ownership pipeline and hold counter.
    always_comb begin
        addr_own_d = addr_own_q;
        data_own_d = data_own_q;
        data_act_d = data_act_q;
        hold_cnt_d = hold_cnt_q;
        if (s_hready_i) begin
            addr_own_d = gnt_idx_q;
            data_own_d = addr_own_q;
            data_act_d = s_htrans_o[1];
            if (s_htrans_o[1] && (hold_cnt_q != HOLD_MAX))
                hold_cnt_d = hold_cnt_q + 1'b1;
        end
        if (grant_chg)
            hold_cnt_d = '0;
`ifdef ARB_ROUND_ROBIN_EN
        last_owner_d = grant_chg ? gnt_idx_d : last_owner_q;
`endif
    end

    always_comb begin
        s_haddr_o  = addr_own_q ? m1_haddr_i  : m0_haddr_i;
        s_htrans_o = !rst_n ? 2'b00 : (addr_own_q ? m1_htrans_i : m0_htrans_i);
        s_hwrite_o = addr_own_q ? m1_hwrite_i : m0_hwrite_i;
        s_hsize_o  = addr_own_q ? m1_hsize_i  : m0_hsize_i;
        s_hburst_o = addr_own_q ? m1_hburst_i : m0_hburst_i;
        s_hwdata_o = data_own_q ? m1_hwdata_i : m0_hwdata_i;
        hready_o   = s_hready_i;
        hresp_o    = s_hresp_i;
        hrdata_o   = s_hrdata_i;
        hmaster_o  = addr_own_q;
    end

endmodule

// File: tb/tb_ahb_two_master_arbiter.sv
// Directed bench for ahb_two_master_arbiter, built with MAX_HOLD=4.
module tb_ahb_two_master_arbiter;

    logic        clk_i = 1'b0, rst_n;
    logic        m0_hbusreq_i, m0_hgrant_o, m0_hwrite_i;
    logic [31:0] m0_haddr_i, m0_hwdata_i;
    logic [1:0]  m0_htrans_i;
    logic [2:0]  m0_hsize_i, m0_hburst_i;
    logic        m1_hbusreq_i, m1_hgrant_o, m1_hwrite_i;
    logic [31:0] m1_haddr_i, m1_hwdata_i;
    logic [1:0]  m1_htrans_i;
    logic [2:0]  m1_hsize_i, m1_hburst_i;
    logic [31:0] s_haddr_o, s_hwdata_o, s_hrdata_i, hrdata_o;
    logic [1:0]  s_htrans_o, s_hresp_i, hresp_o;
    logic        s_hwrite_o, s_hready_i, hready_o, hmaster_o;
    logic [2:0]  s_hsize_o, s_hburst_o;

    int nvec = 0;
    int nerr = 0;

    ahb_two_master_arbiter #(.MAX_HOLD(4), .CNT_W(5)) dut (
        .clk_i(clk_i), .rst_n(rst_n),
        .m0_hbusreq_i(m0_hbusreq_i), .m0_hgrant_o(m0_hgrant_o), .m0_haddr_i(m0_haddr_i),
        .m0_htrans_i(m0_htrans_i), .m0_hwrite_i(m0_hwrite_i), .m0_hsize_i(m0_hsize_i),
        .m0_hburst_i(m0_hburst_i), .m0_hwdata_i(m0_hwdata_i),
        .m1_hbusreq_i(m1_hbusreq_i), .m1_hgrant_o(m1_hgrant_o), .m1_haddr_i(m1_haddr_i),
        .m1_htrans_i(m1_htrans_i), .m1_hwrite_i(m1_hwrite_i), .m1_hsize_i(m1_hsize_i),
        .m1_hburst_i(m1_hburst_i), .m1_hwdata_i(m1_hwdata_i),
        .s_haddr_o(s_haddr_o), .s_htrans_o(s_htrans_o), .s_hwrite_o(s_hwrite_o),
        .s_hsize_o(s_hsize_o), .s_hburst_o(s_hburst_o), .s_hwdata_o(s_hwdata_o),
        .s_hready_i(s_hready_i), .s_hresp_i(s_hresp_i), .s_hrdata_i(s_hrdata_i),
        .hready_o(hready_o), .hresp_o(hresp_o), .hrdata_o(hrdata_o), .hmaster_o(hmaster_o)
    );

    always #5 clk_i = ~clk_i;

    // Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        m0_htrans_i = 2'b10;
        tick(); tick();
        #1;
        nvec++; if (s_htrans_o !== 2'b00) begin nerr++; $display("FAIL rst_htrans got=%b exp=00", s_htrans_o); end
        nvec++; if (m0_hgrant_o !== 1'b1 || m1_hgrant_o !== 1'b0) begin nerr++; $display("FAIL rst_grant got=%b%b exp=01", m1_hgrant_o, m0_hgrant_o); end
        nvec++; if (hmaster_o !== 1'b0) begin nerr++; $display("FAIL rst_hmaster got=%b exp=0", hmaster_o); end
        rst_n = 1'b1;
        m0_htrans_i = 2'b00;
        for (int i = 0; i < 10; i++) begin
            tick(); #1;
            nvec++; if (m0_hgrant_o !== 1'b1 || m1_hgrant_o !== 1'b0) begin nerr++; $display("FAIL idle_grant cyc=%0d got=%b%b exp=01", i, m1_hgrant_o, m0_hgrant_o); end
            nvec++; if (hmaster_o !== 1'b0) begin nerr++; $display("FAIL idle_hmaster cyc=%0d got=%b exp=0", i, hmaster_o); end
            nvec++; if (s_htrans_o !== 2'b00) begin nerr++; $display("FAIL idle_htrans cyc=%0d got=%b exp=00", i, s_htrans_o); end
        end
    endtask

    task automatic test_host_write();
        m1_hbusreq_i = 1'b1;
        m0_hwdata_i  = 32'h5555_5555;
        tick(); #1;
        nvec++; if (m1_hgrant_o !== 1'b1 || m0_hgrant_o !== 1'b0) begin nerr++; $display("FAIL hw_grant got=%b%b exp=10", m1_hgrant_o, m0_hgrant_o); end
        nvec++; if (hmaster_o !== 1'b0) begin nerr++; $display("FAIL hw_hmaster_early got=%b exp=0", hmaster_o); end
        tick();
        m1_htrans_i = 2'b10; m1_haddr_i = 32'hC000_0000; m1_hwrite_i = 1'b1;
        #1;
        nvec++; if (hmaster_o !== 1'b1) begin nerr++; $display("FAIL hw_hmaster got=%b exp=1", hmaster_o); end
        nvec++; if (s_haddr_o !== 32'hC000_0000) begin nerr++; $display("FAIL hw_haddr got=%h exp=c0000000", s_haddr_o); end
        nvec++; if (s_htrans_o !== 2'b10 || s_hwrite_o !== 1'b1) begin nerr++; $display("FAIL hw_ctrl got=%b/%b exp=10/1", s_htrans_o, s_hwrite_o); end
        tick();
        m1_htrans_i = 2'b00; m1_hwrite_i = 1'b0; m1_hwdata_i = 32'h0000_0001; m1_hbusreq_i = 1'b0;
        #1;
        nvec++; if (s_hwdata_o !== 32'h0000_0001) begin nerr++; $display("FAIL hw_hwdata got=%h exp=00000001", s_hwdata_o); end
        tick();
        tick(); #1;
        nvec++; if (m0_hgrant_o !== 1'b1 || hmaster_o !== 1'b0) begin nerr++; $display("FAIL hw_park got=%b/%b exp=1/0", m0_hgrant_o, hmaster_o); end
    endtask

    task automatic test_contention();
        m0_hbusreq_i = 1'b1; m1_hbusreq_i = 1'b1;
        tick(); #1;
`ifdef ARB_ROUND_ROBIN_EN
        nvec++; if (m0_hgrant_o !== 1'b1 || m1_hgrant_o !== 1'b0) begin nerr++; $display("FAIL contend_rr got=%b%b exp=01", m1_hgrant_o, m0_hgrant_o); end
`else
        nvec++; if (m1_hgrant_o !== 1'b1 || m0_hgrant_o !== 1'b0) begin nerr++; $display("FAIL contend_fixed got=%b%b exp=10", m1_hgrant_o, m0_hgrant_o); end
`endif
        m0_hbusreq_i = 1'b0; m1_hbusreq_i = 1'b0;
        tick(); tick(); #1;
        nvec++; if (m0_hgrant_o !== 1'b1 || hmaster_o !== 1'b0) begin nerr++; $display("FAIL contend_park got=%b/%b exp=1/0", m0_hgrant_o, hmaster_o); end
    endtask

    task automatic test_hold_preempt();
        m1_hbusreq_i = 1'b1;
        tick();
        tick();
        m0_hbusreq_i = 1'b1;
        m1_htrans_i = 2'b10; m1_hwrite_i = 1'b0; m1_haddr_i = 32'h0000_1000;
        for (int i = 1; i <= 4; i++) begin
            tick(); #1;
            nvec++; if (m1_hgrant_o !== 1'b1) begin nerr++; $display("FAIL hold_keep beat=%0d got=%b exp=1", i, m1_hgrant_o); end
        end
        nvec++; if (dut.hold_cnt_q !== 5'd4) begin nerr++; $display("FAIL hold_cnt_sat got=%0d exp=4", dut.hold_cnt_q); end
        tick(); #1;
        nvec++; if (m0_hgrant_o !== 1'b1 || m1_hgrant_o !== 1'b0) begin nerr++; $display("FAIL hold_switch got=%b%b exp=01", m1_hgrant_o, m0_hgrant_o); end
        nvec++; if (dut.hold_cnt_q !== 5'd0) begin nerr++; $display("FAIL hold_cnt_clr got=%0d exp=0", dut.hold_cnt_q); end
        m1_htrans_i = 2'b00; m1_hbusreq_i = 1'b0;
    endtask

    task automatic test_wait_handover();
        tick(); #1;
        nvec++; if (hmaster_o !== 1'b0) begin nerr++; $display("FAIL wh_owner0 got=%b exp=0", hmaster_o); end
        m0_htrans_i = 2'b10; m0_hwrite_i = 1'b1; m0_haddr_i = 32'h0000_0100;
        m0_hbusreq_i = 1'b0; m1_hbusreq_i = 1'b1; m1_hwdata_i = 32'h1234_5678;
        tick();
        m0_htrans_i = 2'b00; m0_hwrite_i = 1'b0; m0_hwdata_i = 32'hDEAD_BEEF;
        s_hready_i = 1'b0; s_hresp_i = 2'b01; s_hrdata_i = 32'hA5A5_0F0F;
        #1;
        nvec++; if (m1_hgrant_o !== 1'b1) begin nerr++; $display("FAIL wh_grant got=%b exp=1", m1_hgrant_o); end
        nvec++; if (hready_o !== 1'b0 || hresp_o !== 2'b01 || hrdata_o !== 32'hA5A5_0F0F) begin nerr++; $display("FAIL wh_resp got=%b/%b/%h exp=0/01/a5a50f0f", hready_o, hresp_o, hrdata_o); end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            if (i == 3) begin s_hready_i = 1'b1; s_hresp_i = 2'b00; end
            #1;
            nvec++; if (s_hwdata_o !== 32'hDEAD_BEEF) begin nerr++; $display("FAIL wh_hwdata cyc=%0d got=%h exp=deadbeef", i, s_hwdata_o); end
            nvec++; if (hmaster_o !== 1'b0) begin nerr++; $display("FAIL wh_hold_owner cyc=%0d got=%b exp=0", i, hmaster_o); end
        end
        tick(); #1;
        nvec++; if (hmaster_o !== 1'b1 || m1_hgrant_o !== 1'b1) begin nerr++; $display("FAIL wh_owner1 got=%b/%b exp=1/1", hmaster_o, m1_hgrant_o); end
    endtask

    task automatic test_reset_mid_burst();
        m1_htrans_i = 2'b10; m1_hburst_i = 3'b011; m1_haddr_i = 32'h0000_0200;
        #1;
        nvec++; if (s_hburst_o !== 3'b011 || s_haddr_o !== 32'h0000_0200) begin nerr++; $display("FAIL rb_ctrl got=%b/%h exp=011/00000200", s_hburst_o, s_haddr_o); end
        tick();
        m1_htrans_i = 2'b11; m1_haddr_i = 32'h0000_0204;
        tick();
        m1_haddr_i = 32'h0000_0208;
        rst_n = 1'b0;
        #1;
        nvec++; if (s_htrans_o !== 2'b00) begin nerr++; $display("FAIL rb_htrans_force got=%b exp=00", s_htrans_o); end
        tick();
        rst_n = 1'b1;
        #1;
        nvec++; if (m0_hgrant_o !== 1'b1 || m1_hgrant_o !== 1'b0) begin nerr++; $display("FAIL rb_grant got=%b%b exp=01", m1_hgrant_o, m0_hgrant_o); end
        nvec++; if (s_htrans_o !== 2'b00 || hmaster_o !== 1'b0) begin nerr++; $display("FAIL rb_bus got=%b/%b exp=00/0", s_htrans_o, hmaster_o); end
        nvec++; if (dut.data_act_q !== 1'b0) begin nerr++; $display("FAIL rb_data_act got=%b exp=0", dut.data_act_q); end
        m1_htrans_i = 2'b00; m1_hbusreq_i = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        m0_hbusreq_i = 1'b0; m0_haddr_i = '0; m0_htrans_i = '0; m0_hwrite_i = 1'b0;
        m0_hsize_i = 3'b010; m0_hburst_i = 3'b000; m0_hwdata_i = '0;
        m1_hbusreq_i = 1'b0; m1_haddr_i = '0; m1_htrans_i = '0; m1_hwrite_i = 1'b0;
        m1_hsize_i = 3'b010; m1_hburst_i = 3'b000; m1_hwdata_i = '0;
        s_hready_i = 1'b1; s_hresp_i = 2'b00; s_hrdata_i = '0;
        test_reset();
        test_host_write();
        test_contention();
        test_hold_preempt();
        test_wait_handover();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
